line_winner_scan: RTL and testbench



---
 rtl/line_winner_scan.sv | 174 +++++++++++++++++
 tb/tb_line_winner_scan.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/line_winner_scan.sv
// Sequential N-in-a-row winner scan: snapshots the board on start, checks one line per cycle.
// Optional EARLY_EXIT_EN: leave the scan on the cycle after the first winning line is found.
module line_winner_scan #(
  parameter  int N  = 3,
  localparam int LW = $clog2(2*N+2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2*N*N-1:0]  board,
  output logic              busy,
  output logic              done,
  output logic              ganador,
  output logic [1:0]        who,
  output logic [LW-1:0]     win_line,
  output logic              draw,
  output logic              error
);

  localparam logic [1:0]    IDLE      = 2'd0;
  localparam logic [1:0]    SCAN      = 2'd1;
  localparam logic [1:0]    DONE      = 2'd2;
  localparam logic [LW-1:0] LAST_LINE = LW'(2*N+1);

  logic [1:0]       state_r;
  logic [LW-1:0]    k_r;
  logic [2*N*N-1:0] snap_r;
  logic             empty_r, invalid_r;
  logic             gan_acc_r;
  logic [1:0]       who_acc_r;
  logic [LW-1:0]    line_acc_r;
  logic             busy_r, done_r, ganador_r, draw_r, error_r;
  logic [1:0]       who_r;
  logic [LW-1:0]    win_line_r;

  logic             empty_s, invalid_s;
  logic [1:0]       line_sym_s;
  logic             line_eq_s, line_win_s;
  logic             gan_nxt_s;
  logic [1:0]       who_nxt_s;
  logic [LW-1:0]    line_nxt_s;
  logic             exit_s;

  function automatic logic [1:0] cell_at(input logic [2*N*N-1:0] b, input int r, input int c);
    return b[2*(r*N+c) +: 2];
  endfunction

  // Lines 0..N-1 are rows, N..2N-1 columns, 2N the main and 2N+1 the anti-diagonal.
  function automatic logic [1:0] line_cell(input logic [2*N*N-1:0] b, input int k, input int i);
    logic [1:0] v;
    if (k < N) v = cell_at(b, k, i);
    else if (k < 2*N) v = cell_at(b, i, k - N);
    else if (k == 2*N) v = cell_at(b, i, i);
    else v = cell_at(b, i, N - 1 - i);
    return v;
  endfunction

  // Empty/invalid presence of the board being captured.
  always_comb begin
    empty_s   = 1'b0;
    invalid_s = 1'b0;
    for (int i = 0; i < N*N; i++) begin
      empty_s   = empty_s   | (board[2*i +: 2] == 2'b00);
      invalid_s = invalid_s | (board[2*i +: 2] == 2'b11);
    end
  end

  // Evaluate line k_r of the snapshot; 11 cells fail the symbol test so they never win.
  always_comb begin
    line_sym_s = line_cell(snap_r, int'(k_r), 0);
    line_eq_s  = 1'b1;
    for (int i = 1; i < N; i++) begin
      line_eq_s = line_eq_s & (line_cell(snap_r, int'(k_r), i) == line_sym_s);
    end
    line_win_s = line_eq_s & ((line_sym_s == 2'b01) | (line_sym_s == 2'b10));
  end

  // Keep the earliest winning line; later wins never overwrite it.
  always_comb begin
    gan_nxt_s = gan_acc_r | line_win_s;
    if (gan_acc_r) begin
      who_nxt_s  = who_acc_r;
      line_nxt_s = line_acc_r;
    end else if (line_win_s) begin
      who_nxt_s  = line_sym_s;
      line_nxt_s = k_r;
    end else begin
      who_nxt_s  = 2'b00;
      line_nxt_s = {LW{1'b0}};
    end
  end

`ifdef EARLY_EXIT_EN
  assign exit_s = (k_r == LAST_LINE) | gan_acc_r;
`else
  assign exit_s = (k_r == LAST_LINE);
`endif

  // Scan FSM, accumulators and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      k_r        <= {LW{1'b0}};
      snap_r     <= {(2*N*N){1'b0}};
      empty_r    <= 1'b0;
      invalid_r  <= 1'b0;
      gan_acc_r  <= 1'b0;
      who_acc_r  <= 2'b00;
      line_acc_r <= {LW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ganador_r  <= 1'b0;
      who_r      <= 2'b00;
      win_line_r <= {LW{1'b0}};
      draw_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            snap_r     <= board;
            empty_r    <= empty_s;
            invalid_r  <= invalid_s;
            k_r        <= {LW{1'b0}};
            gan_acc_r  <= 1'b0;
            who_acc_r  <= 2'b00;
            line_acc_r <= {LW{1'b0}};
            busy_r     <= 1'b1;
            state_r    <= SCAN;
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          gan_acc_r  <= gan_nxt_s;
          who_acc_r  <= who_nxt_s;
          line_acc_r <= line_nxt_s;
          k_r        <= k_r + LW'(1);
          if (exit_s) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            ganador_r  <= gan_nxt_s;
            who_r      <= who_nxt_s;
            win_line_r <= line_nxt_s;
            draw_r     <= ~gan_nxt_s & ~empty_r & ~invalid_r;
            error_r    <= invalid_r;
            state_r    <= DONE;
          end else begin
            state_r <= SCAN;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign ganador  = ganador_r;
  assign who      = who_r;
  assign win_line = win_line_r;
  assign draw     = draw_r;
  assign error    = error_r;

endmodule

// File: tb/tb_line_winner_scan.sv
// Bench for line_winner_scan: N=3, 4 and 8 instances checked against a counting reference model.
module tb_line_winner_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [127:0] brd = 128'd0;
  int sel_n = 3;
  int checks = 0;
  int errors = 0;

  logic busy3, done3, gan3, draw3, err3; logic [1:0] who3; logic [2:0] line3;
  logic busy4, done4, gan4, draw4, err4; logic [1:0] who4; logic [3:0] line4;
  logic busy8, done8, gan8, draw8, err8; logic [1:0] who8; logic [4:0] line8;
  logic obs_busy, obs_done, obs_gan, obs_draw, obs_err; logic [1:0] obs_who; logic [7:0] obs_line;

  logic       pg [9];
  logic [1:0] pw [9];
  int         pl [9];

  always #5 clk = ~clk;

  line_winner_scan #(.N(3)) u3 (.clk(clk), .rst_n(rst_n), .start(start && sel_n == 3), .board(brd[17:0]),
    .busy(busy3), .done(done3), .ganador(gan3), .who(who3), .win_line(line3), .draw(draw3), .error(err3));
  line_winner_scan #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start && sel_n == 4), .board(brd[31:0]),
    .busy(busy4), .done(done4), .ganador(gan4), .who(who4), .win_line(line4), .draw(draw4), .error(err4));
  line_winner_scan #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .start(start && sel_n == 8), .board(brd),
    .busy(busy8), .done(done8), .ganador(gan8), .who(who8), .win_line(line8), .draw(draw8), .error(err8));

  always_comb begin
    obs_busy = busy3; obs_done = done3; obs_gan = gan3; obs_who = who3; obs_line = 8'(line3); obs_draw = draw3; obs_err = err3;
    if (sel_n == 4) begin
      obs_busy = busy4; obs_done = done4; obs_gan = gan4; obs_who = who4; obs_line = 8'(line4); obs_draw = draw4; obs_err = err4;
    end else if (sel_n == 8) begin
      obs_busy = busy8; obs_done = done8; obs_gan = gan8; obs_who = who8; obs_line = 8'(line8); obs_draw = draw8; obs_err = err8;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, sel_n, obs, exp);
    end
  endtask

  function automatic logic [127:0] put(input logic [127:0] b, input int n, input int r, input int c, input logic [1:0] v);
    b[2*(r*n+c) +: 2] = v;
    return b;
  endfunction

  // Row/column/diagonal membership of cell (r,c) in line l.
  function automatic bit on_line(input int n, input int l, input int r, input int c);
    if (l < n) return r == l;
    if (l < 2*n) return c == l - n;
    if (l == 2*n) return r == c;
    return r + c == n - 1;
  endfunction

  function automatic logic [127:0] put_line(input logic [127:0] b, input int n, input int l, input logic [1:0] v);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        if (on_line(n, l, r, c)) b = put(b, n, r, c, v);
    return b;
  endfunction

  // Reference: a line wins when it holds n copies of symbol 1 or of symbol 2.
  task automatic model(input int n, input logic [127:0] b, output logic g, output logic [1:0] w,
                       output int ln, output logic d, output logic e);
    logic emp;
    emp = 1'b0; e = 1'b0; g = 1'b0; w = 2'b00; ln = 0;
    for (int i = 0; i < n*n; i++) begin
      if (b[2*i +: 2] == 2'b00) emp = 1'b1;
      if (b[2*i +: 2] == 2'b11) e = 1'b1;
    end
    for (int l = 0; l < 2*n+2; l++) begin
      int c1, c2;
      c1 = 0; c2 = 0;
      for (int r = 0; r < n; r++)
        for (int c = 0; c < n; c++)
          if (on_line(n, l, r, c)) begin
            if (b[2*(r*n+c) +: 2] == 2'b01) c1++;
            if (b[2*(r*n+c) +: 2] == 2'b10) c2++;
          end
      if (!g && (c1 == n || c2 == n)) begin
        g = 1'b1; w = (c1 == n) ? 2'b01 : 2'b10; ln = l;
      end
    end
    d = !g && !emp && !e;
  endtask

  task automatic scan(input int n, input logic [127:0] b, input bit disturb);
    logic g, d, e; logic [1:0] w; int ln; int cnt; int exp_lat; bit seen;
    model(n, b, g, w, ln, d, e);
    sel_n = n; brd = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cnt = 1; seen = 1'b0;
    check("busy_after_start", 32'(obs_busy), 32'd1);
    check("hold_ganador", 32'(obs_gan), 32'(pg[n]));
    check("hold_who", 32'(obs_who), 32'(pw[n]));
    check("hold_line", 32'(obs_line), 32'(pl[n]));
    while (!seen && cnt < 100) begin
      if (obs_done) seen = 1'b1;
      else begin
        start = disturb && cnt == 2;
        if (disturb && cnt == 2) brd = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        cnt++;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    exp_lat = 2*n + 3;
`ifdef EARLY_EXIT_EN
    if (g && ln + 3 < exp_lat) exp_lat = ln + 3;
`endif
    check("latency", 32'(cnt), 32'(exp_lat));
    check("busy_in_done", 32'(obs_busy), 32'd0);
    check("ganador", 32'(obs_gan), 32'(g));
    check("who", 32'(obs_who), 32'(w));
    check("win_line", 32'(obs_line), 32'(ln));
    check("draw", 32'(obs_draw), 32'(d));
    check("error", 32'(obs_err), 32'(e));
    pg[n] = g; pw[n] = w; pl[n] = ln;
    @(negedge clk);
    check("done_one_cycle", 32'(obs_done), 32'd0);
  endtask

  task automatic check_zero(input int n);
    sel_n = n; #1;
    check("rst_busy", 32'(obs_busy), 32'd0);
    check("rst_done", 32'(obs_done), 32'd0);
    check("rst_ganador", 32'(obs_gan), 32'd0);
    check("rst_who", 32'(obs_who), 32'd0);
    check("rst_line", 32'(obs_line), 32'd0);
    check("rst_draw", 32'(obs_draw), 32'd0);
    check("rst_error", 32'(obs_err), 32'd0);
    pg[n] = 1'b0; pw[n] = 2'b00; pl[n] = 0;
  endtask

  initial begin
    logic [127:0] b;
    int n; bit seen;
    for (int i = 0; i < 9; i++) begin pg[i] = 1'b0; pw[i] = 2'b00; pl[i] = 0; end
    repeat (3) @(negedge clk);
    check_zero(3); check_zero(4); check_zero(8);
    rst_n = 1'b1;
    @(negedge clk);

    // Row 1 of player 1.
    scan(3, put_line(128'd0, 3, 1, 2'b01), 1'b0);
    // Anti-diagonal and column 0 of player 2: column 0 (line 3) is reported.
    b = put_line(put_line(128'd0, 3, 7, 2'b10), 3, 3, 2'b10);
    scan(3, b, 1'b0);
    // Full board without a line.
    b = 128'd0;
    b = put(b,3,0,0,2'b01); b = put(b,3,0,1,2'b10); b = put(b,3,0,2,2'b01);
    b = put(b,3,1,0,2'b01); b = put(b,3,1,1,2'b10); b = put(b,3,1,2,2'b10);
    b = put(b,3,2,0,2'b10); b = put(b,3,2,1,2'b01); b = put(b,3,2,2,2'b01);
    scan(3, b, 1'b0);
    // N=4 row 0 = 11,01,01,01.
    b = put_line(128'd0, 4, 0, 2'b01); b = put(b, 4, 0, 0, 2'b11);
    scan(4, b, 1'b0);
    // Board change and extra start while busy.
    scan(3, put_line(128'd0, 3, 4, 2'b10), 1'b1);

    // Reset mid-scan.
    sel_n = 3; brd = put_line(128'd0, 3, 0, 2'b01); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_mid_scan", 32'(obs_busy), 32'd1);
    rst_n = 1'b0;
    check_zero(3);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (done3) seen = 1'b1; end
    check("no_done_after_reset", 32'(seen), 32'd0);
    scan(3, put_line(128'd0, 3, 6, 2'b01), 1'b0);

    // N=8 main diagonal of player 1.
    scan(8, put_line(128'd0, 8, 16, 2'b01), 1'b0);

    // Randomized boards, back-to-back starts.
    for (int t = 0; t < 36; t++) begin
      n = (t % 3 == 0) ? 3 : ((t % 3 == 1) ? 4 : 8);
      b = 128'd0;
      for (int i = 0; i < n*n; i++) begin
        logic [1:0] v;
        v = 2'($urandom_range((t % 4 == 0) ? 1 : 0, 2));
        if ($urandom_range(0, 19) == 0) v = 2'b11;
        b[2*i +: 2] = v;
      end
      if ($urandom_range(0, 2) != 0) b = put_line(b, n, $urandom_range(0, 2*n+1), 2'($urandom_range(1, 2)));
      scan(n, b, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
